// File: rtl/serial_adder_seq_if.sv
// Bus bundle for serial_adder_seq: start/busy/done handshake, operands and result.
// Optional signed-overflow flag present only when SERIAL_ADDER_OVF_EN is defined.
//
// Handshake: the master raises start with a/b/c_in valid; the request is taken on
// the first rising edge where the slave is not busy (IDLE or DONE) and rst is low.
// busy is high for the whole operation and start is ignored while it is high.
// done pulses for one cycle when sum/c_out (and ovf) carry the new result.
// The result outputs then hold until the next accepted request completes.
interface serial_adder_seq_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif
  // Debug view of the FSM encoding: 0 = IDLE, 1 = RUN, 2 = DONE.
  logic [1:0]       fsm_state;

`ifdef SERIAL_ADDER_OVF_EN
  modport master (output start, a, b, c_in,
                  input  busy, done, sum, c_out, ovf, fsm_state);
  modport slave  (input  start, a, b, c_in,
                  output busy, done, sum, c_out, ovf, fsm_state);
`else
  modport master (output start, a, b, c_in,
                  input  busy, done, sum, c_out, fsm_state);
  modport slave  (input  start, a, b, c_in,
                  output busy, done, sum, c_out, fsm_state);
`endif
endinterface

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: multi-cycle adder computing a + b + c_in, DIGIT bits per clock,
// through one DIGIT-bit adder slice and a carry flop. Result registers hold until
// the next operation completes.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag.
module serial_adder_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_seq_if.slave  bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder_seq: illegal WIDTH=%0d / DIGIT=%0d", WIDTH, DIGIT);
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic                 last_step;
  logic [WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]     b_sh;
  logic [WIDTH-1:0]     res_sh;
  logic                 carry;
  logic [CW-1:0]        cnt;
  logic [DIGIT:0]       slice;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]     res_next;
`ifdef SERIAL_ADDER_OVF_EN
  logic                 a_msb;
  logic                 b_msb;
`endif

  // One DIGIT-bit adder slice; the new digit enters the result from the MSB end so
  // that after STEPS shifts the first digit has reached bit 0.
  assign slice     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
  assign res_cat   = {slice[DIGIT-1:0], res_sh};
  assign res_next  = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_step = (cnt == LAST);
  assign bus.fsm_state = state;

  // State register; reset overrides any pending start.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic, request acceptance and the busy/done status outputs.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one digit per RUN cycle, publish on the last.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      bus.sum   <= '0;
      bus.c_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      bus.ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      res_sh <= '0;
      carry  <= bus.c_in;
      cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      a_msb  <= bus.a[WIDTH-1];
      b_msb  <= bus.b[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res_sh <= res_next;
      carry  <= slice[DIGIT];
      cnt    <= cnt + 1'b1;
      if (last_step) begin
        bus.sum   <= res_next;
        bus.c_out <= slice[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
        bus.ovf   <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq: three instances (8x1, 4x1, 8x4),
// directed vectors with hand-computed results, plus a 4-bit exhaustive sweep.
module tb_serial_adder_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_seq_if #(.WIDTH(8)) if8  ();
  serial_adder_seq_if #(.WIDTH(4)) if4  ();
  serial_adder_seq_if #(.WIDTH(8)) if84 ();

  serial_adder_seq #(.WIDTH(8), .DIGIT(1)) u8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder_seq #(.WIDTH(4), .DIGIT(1)) u4  (.clk(clk), .rst(rst), .bus(if4));
  serial_adder_seq #(.WIDTH(8), .DIGIT(4)) u84 (.clk(clk), .rst(rst), .bus(if84));

  // ---------------- scoreboard ----------------
  int         n_vec = 0;
  int         n_err = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  // Start an 8x1 op, wait (bounded) for done, check latency and result.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [7:0] exp_sum, input logic exp_c);
    int n;
    if8.a     = a;
    if8.b     = b;
    if8.c_in  = cin;
    if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    n = 0;
    while (!if8.done && n < 20) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, 8);
    check({tag, " sum"}, if8.sum, exp_sum);
    check({tag, " c_out"}, if8.c_out, exp_c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int pulses;
    logic [4:0] exp;

    rst = 1'b1;
    if8.start = 0;  if8.a = 0;  if8.b = 0;  if8.c_in = 0;
    if4.start = 0;  if4.a = 0;  if4.b = 0;  if4.c_in = 0;
    if84.start = 0; if84.a = 0; if84.b = 0; if84.c_in = 0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    check("rst busy", if8.busy, 0);
    check("rst done", if8.done, 0);
    check("rst sum", if8.sum, 0);
    check("rst c_out", if8.c_out, 0);
    check("rst state", if8.fsm_state, 0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst ovf", if8.ovf, 0);
`endif

    // FF + 01 + 0: busy for 8 cycles, then done with sum 00, carry 1
    if8.a = 8'hFF; if8.b = 8'h01; if8.c_in = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    if8.a = 8'h00; if8.b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1 busy%0d", i), if8.busy, 1);
      check($sformatf("t1 nodone%0d", i), if8.done, 0);
      tick();
    end
    check("t1 done", if8.done, 1);
    check("t1 busy_low", if8.busy, 0);
    check("t1 sum", if8.sum, 8'h00);
    check("t1 c_out", if8.c_out, 1);
    tick();
    check("t1 done_pulse", if8.done, 0);
    check("t1 idle", if8.fsm_state, 0);

    // Boundaries and assorted patterns (back-to-back from DONE)
    run8("ones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run8("zeros", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run8("pos_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
    check("pos_ovf ovf", if8.ovf, 1);
`endif
    run8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    check("ff_01 ovf", if8.ovf, 0);
`endif
    run8("neg_ovf", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
`ifdef SERIAL_ADDER_OVF_EN
    check("neg_ovf ovf", if8.ovf, 1);
`endif
    run8("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    tick();

    // Start during RUN is ignored; previous sum holds until done
    if8.a = 8'h10; if8.b = 8'h20; if8.c_in = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    check("t4 hold1", if8.sum, 8'h46);
    if8.a = 8'hFF; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    check("t4 busy", if8.busy, 1);
    check("t4 hold2", if8.sum, 8'h46);
    n = 0;
    while (!if8.done && n < 20) begin
      check($sformatf("t4 hold_w%0d", n), if8.sum, 8'h46);
      tick();
      n++;
    end
    check("t4 latency", n, 5);
    check("t4 sum", if8.sum, 8'h30);
    check("t4 c_out", if8.c_out, 0);
    tick();
    check("t4 no_restart", if8.busy, 0);
    check("t4 done_low", if8.done, 0);

    // Reset mid-operation aborts; no done pulse follows
    if8.a = 8'h55; if8.b = 8'h0F; if8.c_in = 1'b1; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5 busy", if8.busy, 0);
    check("t5 done", if8.done, 0);
    check("t5 sum", if8.sum, 0);
    check("t5 c_out", if8.c_out, 0);
    check("t5 state", if8.fsm_state, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (if8.done || if8.busy) pulses++;
      tick();
    end
    check("t5 no_done", pulses, 0);

    // rst and start together: start not accepted
    if8.a = 8'h01; if8.b = 8'h01; if8.start = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; if8.start = 1'b0;
    check("rst_start busy", if8.busy, 0);
    tick();
    check("rst_start busy2", if8.busy, 0);
    check("rst_start done", if8.done, 0);

    // 8x4: A5 + 5A + 1 -> 00 carry 1, done 2 edges after the accepting edge
    if84.a = 8'hA5; if84.b = 8'h5A; if84.c_in = 1'b1; if84.start = 1'b1;
    tick();
    if84.start = 1'b0;
    n = 0;
    while (!if84.done && n < 20) begin
      tick();
      n++;
    end
    check("d4 latency", n, 2);
    check("d4 sum", if84.sum, 8'h00);
    check("d4 c_out", if84.c_out, 1);

    // 4x1 exhaustive, back-to-back starts from DONE
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          if4.a = 4'(a); if4.b = 4'(b); if4.c_in = c[0]; if4.start = 1'b1;
          tick();
          exp_q.push_back(5'(a + b + c));
          check($sformatf("x4 busy %0d+%0d+%0d", a, b, c), if4.busy, 1);
          for (int k = 0; k < 4; k++) tick();
          check($sformatf("x4 done %0d+%0d+%0d", a, b, c), if4.done, 1);
          exp = exp_q.pop_front();
          check($sformatf("x4 res %0d+%0d+%0d", a, b, c), {if4.c_out, if4.sum}, exp);
        end
      end
    end
    if4.start = 1'b0;
    tick();
    check("x4 final idle", if4.fsm_state, 0);
    check("x4 queue empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
